// File: rtl/mem_access_ctrl.sv
// Shared memory port sequencer: round-robin arbitration between instruction fetch
// and load/store, MAR/MDR latching, fixed-latency access and one-cycle completion pulses.
module mem_access_ctrl #(
  parameter int BITS_DATA   = 32,
  parameter int BITS_ADDR   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_fetch,
  input  logic [BITS_ADDR-1:0] addr_fetch,
  input  logic                 req_data,
  input  logic                 we_data,
  input  logic [BITS_ADDR-1:0] addr_data,
  input  logic [BITS_DATA-1:0] wdata_data,
  output logic                 grant_fetch,
  output logic                 grant_data,
  output logic                 done_fetch,
  output logic                 done_data,
  output logic [BITS_DATA-1:0] rdata,
  output logic                 busy,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [BITS_ADDR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  input  logic [BITS_DATA-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BITS_ADDR-1:0] mar;
  logic [BITS_DATA-1:0] mdr;
  logic                 served_data;
  logic                 last_data;
  logic                 pick_data;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    pick_data   = req_data && (!req_fetch || !last_data);
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (!reset && state == IDLE) begin
      grant_data  = pick_data;
      grant_fetch = req_fetch && !pick_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      mar         <= '0;
      mdr         <= '0;
      served_data <= 1'b0;
      last_data   <= 1'b1;
      busy        <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      done_fetch  <= 1'b0;
      done_data   <= 1'b0;
    end else begin
      done_fetch <= 1'b0;
      done_data  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fetch || grant_data) begin
            state       <= ACCESS;
            cnt         <= CNT_W'(1);
            busy        <= 1'b1;
            mem_en      <= 1'b1;
            served_data <= grant_data;
            last_data   <= grant_data;
            if (grant_data) begin
              mar    <= addr_data;
              mem_we <= we_data;
              if (we_data) mdr <= wdata_data;
            end else begin
              mar    <= addr_fetch;
              mem_we <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == CNT_W'(MEM_LATENCY)) begin
            // Stores keep their write data in MDR; only reads capture the bus.
            if (!mem_we) mdr <= mem_rdata;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            done_fetch <= !served_data;
            done_data  <= served_data;
            state      <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rdata     = mdr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: two instances (latency 2 and 1) compared every cycle against a
// transaction-timeline model, plus directed checks with hand-computed values.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int LAT [2] = '{2, 1};

  logic        rst    [2];
  logic        req_f  [2];
  logic        req_d  [2];
  logic        we_d   [2];
  logic [15:0] addr_f [2];
  logic [15:0] addr_d [2];
  logic [31:0] wd     [2];

  logic        gf [2], gd [2], df [2], dd [2], bsy [2], men [2], mwe [2];
  logic [15:0] maddr [2];
  logic [31:0] mwd [2], rdat [2], mrd [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Memory contents seen by both instances (writes are not stored).
  function automatic logic [31:0] mem_val(input logic [15:0] a);
    return (a == 16'h0040) ? 32'hDEADBEEF : {a ^ 16'hA5A5, a};
  endfunction

  assign mrd[0] = mem_val(maddr[0]);
  assign mrd[1] = mem_val(maddr[1]);

  mem_access_ctrl #(.MEM_LATENCY(2)) dut_a (
    .clk(clk), .reset(rst[0]),
    .req_fetch(req_f[0]), .addr_fetch(addr_f[0]),
    .req_data(req_d[0]), .we_data(we_d[0]), .addr_data(addr_d[0]), .wdata_data(wd[0]),
    .grant_fetch(gf[0]), .grant_data(gd[0]), .done_fetch(df[0]), .done_data(dd[0]),
    .rdata(rdat[0]), .busy(bsy[0]), .mem_en(men[0]), .mem_we(mwe[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
  );

  mem_access_ctrl #(.MEM_LATENCY(1)) dut_b (
    .clk(clk), .reset(rst[1]),
    .req_fetch(req_f[1]), .addr_fetch(addr_f[1]),
    .req_data(req_d[1]), .we_data(we_d[1]), .addr_data(addr_d[1]), .wdata_data(wd[1]),
    .grant_fetch(gf[1]), .grant_data(gd[1]), .done_fetch(df[1]), .done_data(dd[1]),
    .rdata(rdat[1]), .busy(bsy[1]), .mem_en(men[1]), .mem_we(mwe[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: ph = cycles since grant (-1 when idle); access occupies 1..LAT, response LAT+1.
  int          ph      [2] = '{-1, -1};
  logic        srv_d   [2] = '{1'b0, 1'b0};
  logic        last_d  [2] = '{1'b1, 1'b1};
  logic        mwe_m   [2] = '{1'b0, 1'b0};
  logic [15:0] mar_m   [2] = '{16'h0, 16'h0};
  logic [31:0] mdr_m   [2] = '{32'h0, 32'h0};
  logic        chk_en  [2] = '{1'b0, 1'b0};

  // Returns {data, fetch} grant the model expects this cycle.
  function automatic logic [1:0] exp_grant(input int i);
    if (rst[i] || ph[i] >= 0) return 2'b00;
    if (req_f[i] && req_d[i]) return last_d[i] ? 2'b01 : 2'b10;
    if (req_f[i]) return 2'b01;
    if (req_d[i]) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        ph[i]     <= -1;
        mar_m[i]  <= '0;
        mdr_m[i]  <= '0;
        mwe_m[i]  <= 1'b0;
        last_d[i] <= 1'b1;
        chk_en[i] <= 1'b1;
      end else if (ph[i] < 0) begin
        if (exp_grant(i) != 2'b00) begin
          srv_d[i]  <= exp_grant(i) == 2'b10;
          last_d[i] <= exp_grant(i) == 2'b10;
          mar_m[i]  <= (exp_grant(i) == 2'b10) ? addr_d[i] : addr_f[i];
          mwe_m[i]  <= (exp_grant(i) == 2'b10) && we_d[i];
          if (exp_grant(i) == 2'b10 && we_d[i]) mdr_m[i] <= wd[i];
          ph[i]     <= 1;
        end
      end else if (ph[i] < LAT[i]) begin
        ph[i] <= ph[i] + 1;
      end else if (ph[i] == LAT[i]) begin
        if (!mwe_m[i]) mdr_m[i] <= mem_val(mar_m[i]);
        ph[i] <= ph[i] + 1;
      end else begin
        ph[i] <= -1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] g;
    logic       acc, resp;
    for (int i = 0; i < 2; i++) begin
      if (chk_en[i]) begin
        g    = exp_grant(i);
        acc  = ph[i] >= 1 && ph[i] <= LAT[i];
        resp = ph[i] == LAT[i] + 1;
        check($sformatf("model_ctrl[%0d]", i),
              64'({gf[i], gd[i], df[i], dd[i], bsy[i], men[i], mwe[i]}),
              64'({g[0], g[1], resp && !srv_d[i], resp && srv_d[i], ph[i] >= 1, acc,
                   acc && mwe_m[i]}));
        check($sformatf("model_addr[%0d]", i), 64'(maddr[i]), 64'(mar_m[i]));
        check($sformatf("model_wdata[%0d]", i), 64'(mwd[i]), 64'(mdr_m[i]));
        check($sformatf("model_rdata[%0d]", i), 64'(rdat[i]), 64'(mdr_m[i]));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [2:0] t6_exp [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
  int gcnt;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_f[i] = 1'b0; req_d[i] = 1'b0; we_d[i] = 1'b0;
      addr_f[i] = '0; addr_d[i] = '0; wd[i] = '0;
    end
    req_f[0]  = 1'b1;
    addr_f[0] = 16'h0040;

    // 1: reset holds everything low even with a pending fetch
    repeat (2) begin
      sample();
      check("t1_rst_ctrl", 64'({gf[0], gd[0], bsy[0], men[0], df[0]}), 64'(0));
      check("t1_rst_rdata", 64'(rdat[0]), 64'(0));
    end
    next_cycle(); rst[0] = 1'b0;
    sample();
    check("t1_first_grant_fetch", 64'({gf[0], gd[0]}), 64'(2'b10));

    // 2: single fetch from 0x0040
    next_cycle(); req_f[0] = 1'b0;
    sample();
    check("t2_acc1", 64'({men[0], mwe[0], maddr[0]}), 64'({2'b10, 16'h0040}));
    next_cycle(); sample();
    check("t2_acc2", 64'({men[0], mwe[0], maddr[0]}), 64'({2'b10, 16'h0040}));
    next_cycle(); sample();
    check("t2_done", 64'({df[0], dd[0], men[0]}), 64'(3'b100));
    check("t2_rdata", 64'(rdat[0]), 64'(32'hDEADBEEF));

    // 3: store 0xAA to 0x1234
    next_cycle();
    req_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 16'h1234; wd[0] = 32'h0000_00AA;
    sample();
    check("t3_grant_data", 64'({gf[0], gd[0]}), 64'(2'b01));
    next_cycle(); req_d[0] = 1'b0; we_d[0] = 1'b0; wd[0] = '0;
    repeat (2) begin
      sample();
      check("t3_store_bus", 64'({men[0], mwe[0], maddr[0], mwd[0]}),
            64'({2'b11, 16'h1234, 32'h0000_00AA}));
      next_cycle();
    end
    sample();
    check("t3_done", 64'({df[0], dd[0]}), 64'(2'b01));
    check("t3_rdata", 64'(rdat[0]), 64'(32'h0000_00AA));

    // 4: both requesters held; grants alternate every 4 cycles starting with fetch
    next_cycle();
    req_f[0] = 1'b1; req_d[0] = 1'b1; addr_f[0] = 16'h0080; addr_d[0] = 16'h0300;
    gcnt = 0;
    for (int c = 0; c < 32; c++) begin
      sample();
      if (gf[0] || gd[0]) begin
        check("t4_order", 64'({gf[0], gd[0]}), (gcnt % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
        check("t4_spacing", 64'(c), 64'(4 * gcnt));
        gcnt++;
      end
      next_cycle();
    end
    check("t4_grant_count", 64'(gcnt), 64'(8));
    req_f[0] = 1'b0; req_d[0] = 1'b0;

    // 5: reset in the first access cycle of a read aborts it
    sample();
    next_cycle(); req_f[0] = 1'b1; addr_f[0] = 16'h0100;
    sample();
    check("t5_grant", 64'(gf[0]), 64'(1));
    next_cycle(); req_f[0] = 1'b0; rst[0] = 1'b1;
    sample();
    check("t5_acc_before_abort", 64'(men[0]), 64'(1));
    next_cycle(); rst[0] = 1'b0;
    sample();
    check("t5_aborted", 64'({men[0], bsy[0], df[0]}), 64'(0));
    check("t5_rdata_cleared", 64'(rdat[0]), 64'(0));
    next_cycle(); req_f[0] = 1'b1; req_d[0] = 1'b1;
    sample();
    check("t5_fetch_wins_after_reset", 64'({gf[0], gd[0], df[0]}), 64'(3'b100));
    next_cycle(); req_f[0] = 1'b0; req_d[0] = 1'b0;
    repeat (4) begin sample(); next_cycle(); end

    // 6: latency-1 instance, back-to-back fetches
    rst[1] = 1'b0; req_f[1] = 1'b1; addr_f[1] = 16'h0200;
    for (int c = 0; c < 6; c++) begin
      sample();
      check($sformatf("t6_c%0d", c), 64'({gf[1], men[1], df[1]}), 64'(t6_exp[c]));
      if (c == 2) check("t6_rdata", 64'(rdat[1]), 64'(32'hA7A5_0200));
      next_cycle();
    end
    req_f[1] = 1'b0;
    repeat (3) begin sample(); next_cycle(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
